// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: a 4-deep byte FIFO feeding an 11-bit frame
// serializer (start, 8 data LSB first, odd parity, stop). The device drives
// its own PS/2 clock. Data changes only while sclk is high, so the host can
// sample on each falling edge.
module ps2_dev_tx #(
  parameter int HALF_CYC = 5000,
  parameter int GAP_CYC  = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_ps2_sclk,
  output logic       o_ps2_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam int MAXC = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd10;

  logic [7:0]    r_mem [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_byte;
  logic          r_sclk;
  logic          r_data;
  logic          r_done;
  logic          w_push;
  logic          w_pop;
  logic [3:0]    w_next_bit;

  // Line level for frame position idx: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic [3:0] k;
    k = idx - 4'd1;
    if (idx == 4'd0)       return 1'b0;
    else if (idx <= 4'd8)  return d[k[2:0]];
    else if (idx == 4'd9)  return ~^d;
    else                   return 1'b1;
  endfunction

  assign o_ready    = (r_count != 3'd4);
  assign w_push     = i_valid & o_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != 3'd0);
  assign w_next_bit = r_bit + 4'd1;
  assign o_busy     = (r_state != S_IDLE);
  assign o_ps2_sclk = r_sclk;
  assign o_ps2_data = r_data;
  assign o_done     = r_done;

  // FIFO storage and the byte being serialized; pure data, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
    if (w_pop)  r_byte <= r_mem[r_rd_ptr];
  end

  // FIFO pointers and occupancy; push and pop in the same cycle cancel in the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM: each bit is HALF_CYC cycles of sclk high followed by HALF_CYC low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_sclk  <= 1'b1;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_sclk  <= 1'b1;
            r_data  <= 1'b0;
          end
        end
        S_HIGH: begin
          if (r_cnt == HALF_LAST) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_sclk  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt  <= '0;
            r_sclk <= 1'b1;
            if (r_bit == LAST_BIT) begin
              r_state <= S_GAP;
              r_data  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_HIGH;
              r_bit   <= w_next_bit;
              r_data  <= frame_bit(r_byte, w_next_bit);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
